// File: rtl/pic_param_ctrl_if.sv
// -----------------------------------------------------------------------------
// pic_param_ctrl_if
// CPU-side bus of the programmable interrupt controller.
//   cs, wr, rd   : chip select and one-cycle read/write strobes (wr/rd need cs)
//   addr         : register select
//   din          : write data
//   dout         : read data, or the interrupt vector during acknowledge
//   dout_valid   : dout holds valid data this cycle
//   intr         : interrupt request to the CPU, active high
//   inta_n       : CPU acknowledge, active low, two low pulses per acknowledge
// The master modport is the CPU side; the slave modport is the controller.
// -----------------------------------------------------------------------------
interface pic_param_ctrl_if #(
  parameter int DW = 8
);
  logic          cs;
  logic          wr;
  logic          rd;
  logic [1:0]    addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          intr;
  logic          inta_n;

  modport master (
    output cs, wr, rd, addr, din, inta_n,
    input  dout, dout_valid, intr
  );

  modport slave (
    input  cs, wr, rd, addr, din, inta_n,
    output dout, dout_valid, intr
  );
endinterface

// File: rtl/pic_param_ctrl.sv
// -----------------------------------------------------------------------------
// pic_param_ctrl
// Parametrised programmable interrupt controller with fixed or rotating
// priority, fully nested service, auto/specific/non-specific EOI and a global
// level/edge trigger mode.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   ir_i    : NUM_IRQ request lines, synchronous to clk_i
//   bus     : CPU register port and acknowledge handshake (slave modport)
// Register map (addr):
//   0 : write CTRL {ROTATE, AEOI, LTIM}, read IRR
//   1 : IMR read/write
//   2 : write EOI {specific at bit 7, level in low bits}, read ISR
//   3 : BASE read/write; vector = {BASE[DW-1:IDX_W], idx}
// -----------------------------------------------------------------------------
module pic_param_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int DW      = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] ir_i,
  pic_param_ctrl_if.slave    bus
);

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_IRQ - 1);
  localparam logic [IDX_W:0]   NUM_Q        = (IDX_W + 1)'(NUM_IRQ);
  localparam int               EOI_SPEC_BIT = (DW > 7) ? 7 : DW - 1;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_IMR  = 2'd1;
  localparam logic [1:0] A_EOI  = 2'd2;
  localparam logic [1:0] A_BASE = 2'd3;

  localparam int C_LTIM = 0;
  localparam int C_AEOI = 1;
  localparam int C_ROT  = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK1 = 1'b1
  } state_e;

  // Distance of idx below the current top-priority line; 0 = highest.
  function automatic logic [IDX_W-1:0] rank_of(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] top);
    logic [IDX_W:0] s;
    s = {1'b0, idx} + NUM_Q - {1'b0, top};
    if (s >= NUM_Q) s = s - NUM_Q;
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [DW-1:0] make_vec(input logic [DW-1:0]    base,
                                             input logic [IDX_W-1:0] idx);
    logic [DW-1:0] v;
    v            = base;
    v[IDX_W-1:0] = idx;
    return v;
  endfunction

  // Register state
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [NUM_IRQ-1:0] ir_prev_q;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [DW-1:0]      base_q, base_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  // Acknowledge FSM state and registered outputs
  state_e             state_q;
  logic [IDX_W-1:0]   vidx_q;
  logic [DW-1:0]      vec_q;
  logic               spur_q;
  logic               int_q;
  logic               inta_prev_q;
  logic               vec_drv_q;
  logic [DW-1:0]      dout_q;
  logic               dout_valid_q;

  // Decode
  logic               wr_en, rd_en, inta_fall, ack1_evt, ack2_evt;
  logic [NUM_IRQ-1:0] req;
  logic [IDX_W-1:0]   eff_ptr;
  logic               req_found, isr_found, eligible;
  logic [IDX_W-1:0]   req_idx, req_rank, isr_idx, isr_rank;
  logic [IDX_W-1:0]   eoi_lvl;
  logic [DW-1:0]      rd_data;

  assign wr_en     = bus.cs & bus.wr;
  assign rd_en     = bus.cs & bus.rd;
  assign inta_fall = ~bus.inta_n & inta_prev_q;
  assign ack1_evt  = (state_q == S_IDLE) & inta_fall;
  assign ack2_evt  = (state_q == S_ACK1) & inta_fall;
  assign req       = irr_q & ~imr_q;
  // In fixed mode line 0 is always on top, whatever the pointer holds.
  assign eff_ptr   = ctrl_q[C_ROT] ? ptr_q : '0;

  // Best pending request and best in-service line, both by rank.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    req_rank  = '0;
    isr_found = 1'b0;
    isr_idx   = '0;
    isr_rank  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && (!req_found || rank_of(IDX_W'(i), eff_ptr) < req_rank)) begin
        req_found = 1'b1;
        req_idx   = IDX_W'(i);
        req_rank  = rank_of(IDX_W'(i), eff_ptr);
      end
      if (isr_q[i] && (!isr_found || rank_of(IDX_W'(i), eff_ptr) < isr_rank)) begin
        isr_found = 1'b1;
        isr_idx   = IDX_W'(i);
        isr_rank  = rank_of(IDX_W'(i), eff_ptr);
      end
    end
  end

  // Fully nested: a request only counts if it outranks everything in service.
  assign eligible = req_found & (~isr_found | (req_rank < isr_rank));

  // Next-state for the register file, IRR and ISR.
  always_comb begin
    irr_d   = irr_q;
    isr_d   = isr_q;
    imr_d   = imr_q;
    ctrl_d  = ctrl_q;
    base_d  = base_q;
    ptr_d   = ptr_q;
    eoi_lvl = '0;

    if (ack2_evt && ctrl_q[C_AEOI] && !spur_q) begin
      isr_d[vidx_q] = 1'b0;
      if (ctrl_q[C_ROT]) ptr_d = next_idx(vidx_q);
    end

    if (wr_en) begin
      case (bus.addr)
        A_CTRL: ctrl_d = bus.din[2:0];
        A_IMR:  imr_d  = bus.din[NUM_IRQ-1:0];
        A_EOI: begin
          // With nothing in service an EOI is ignored, pointer included.
          if (|isr_q) begin
            eoi_lvl = bus.din[EOI_SPEC_BIT] ? bus.din[IDX_W-1:0] : isr_idx;
            if ({1'b0, eoi_lvl} < NUM_Q) begin
              isr_d[eoi_lvl] = 1'b0;
              if (ctrl_q[C_ROT]) ptr_d = next_idx(eoi_lvl);
            end
          end
        end
        A_BASE: base_d = bus.din;
        default: ;
      endcase
    end

    if (ack1_evt && eligible) isr_d[req_idx] = 1'b1;

    if (ctrl_q[C_LTIM]) begin
      irr_d = ir_i;
    end else begin
      if (ack1_evt && eligible) irr_d[req_idx] = 1'b0;
      // Applied after the clear so a fresh edge on the acked line survives.
      irr_d = irr_d | (ir_i & ~ir_prev_q);
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      A_CTRL:  rd_data[NUM_IRQ-1:0] = irr_q;
      A_IMR:   rd_data[NUM_IRQ-1:0] = imr_q;
      A_EOI:   rd_data[NUM_IRQ-1:0] = isr_q;
      default: rd_data              = base_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= '1;
      ctrl_q    <= '0;
      base_q    <= '0;
      ptr_q     <= '0;
      ir_prev_q <= '0;
    end else begin
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      ctrl_q    <= ctrl_d;
      base_q    <= base_d;
      ptr_q     <= ptr_d;
      ir_prev_q <= ir_i;
    end
  end

  // Acknowledge FSM with registered INT and DOUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      vidx_q       <= '0;
      vec_q        <= '0;
      spur_q       <= 1'b0;
      int_q        <= 1'b0;
      inta_prev_q  <= 1'b1;
      vec_drv_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      inta_prev_q <= bus.inta_n;
      int_q       <= eligible;
      // Keep presenting the vector for as long as the second pulse is held.
      vec_drv_q   <= ack2_evt | (vec_drv_q & ~bus.inta_n);

      case (state_q)
        S_IDLE: begin
          if (inta_fall) begin
            state_q <= S_ACK1;
            int_q   <= 1'b0;
            spur_q  <= ~eligible;
            vidx_q  <= eligible ? req_idx : LAST_IDX;
            vec_q   <= make_vec(base_q, eligible ? req_idx : LAST_IDX);
          end
        end
        S_ACK1: begin
          if (inta_fall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (ack2_evt || (vec_drv_q && !bus.inta_n)) begin
        dout_q       <= vec_q;
        dout_valid_q <= 1'b1;
      end else if (rd_en) begin
        dout_q       <= rd_data;
        dout_valid_q <= 1'b1;
      end else begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.intr       = int_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_pic_param_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pic_param_ctrl
// Self-checking bench for pic_param_ctrl (NUM_IRQ=8, DW=8): a register-access
// vector table, hand-written acknowledge/EOI sequences, and a randomized run
// against a priority-walk reference model.
// -----------------------------------------------------------------------------
module tb_pic_param_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir = 8'h00;

  always #5 clk = ~clk;

  pic_param_ctrl_if #(.DW(8)) bus ();

  pic_param_ctrl #(.NUM_IRQ(8), .DW(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ir_i   (ir),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] ir;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];

  // Reference model state
  logic [7:0] m_irr, m_isr, m_imr, m_base, m_ir;
  int         m_ptr;
  bit         m_aeoi, m_rot;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    ir = 8'h00;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.addr = 2'd0; bus.din = 8'h00; bus.inta_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       v;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    d = bus.dout;
    v = bus.dout_valid;
    bus.cs = 1'b0; bus.rd = 1'b0;
    chk(nm, 32'({v, d}), 32'({1'b1, exp}));
  endtask

  // Full two-pulse acknowledge; returns what DOUT showed on the second pulse.
  task automatic ack(output logic [7:0] v, output logic vl);
    bus.inta_n = 1'b0; @(negedge clk);
    bus.inta_n = 1'b1; @(negedge clk);
    bus.inta_n = 1'b0; @(negedge clk);
    v  = bus.dout;
    vl = bus.dout_valid;
    bus.inta_n = 1'b1; @(negedge clk);
  endtask

  // Walk lines from the top-priority one downwards: an in-service line met
  // first blocks everything below it.
  function automatic int m_winner();
    int top = m_rot ? m_ptr : 0;
    for (int r = 0; r < 8; r++) begin
      int l = (top + r) % 8;
      if (m_isr[l]) return -1;
      if (m_irr[l] && !m_imr[l]) return l;
    end
    return -1;
  endfunction

  function automatic int m_top_isr();
    int top = m_rot ? m_ptr : 0;
    for (int r = 0; r < 8; r++) begin
      int l = (top + r) % 8;
      if (m_isr[l]) return l;
    end
    return -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic       vl;
    logic [7:0] nir, e;
    int         w, lvl, c;
    bit         sp;

    tbl[0]  = '{1'b0, 2'd1, 8'h00, 8'h00, 8'hFF};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 2'd2, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 2'd3, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 2'd3, 8'hB8, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 2'd3, 8'h00, 8'h00, 8'hB8};
    tbl[6]  = '{1'b1, 2'd1, 8'h5A, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 2'd1, 8'h00, 8'h00, 8'h5A};
    tbl[8]  = '{1'b1, 2'd0, 8'h01, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 8'h24, 8'h24};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 8'h81, 8'h81};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{1'b1, 2'd0, 8'h00, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 8'h11, 8'h11};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h11};
    tbl[15] = '{1'b0, 2'd0, 8'h00, 8'h13, 8'h13};

    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.addr = 2'd0; bus.din = 8'h00; bus.inta_n = 1'b1;

    // Register-access table
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      ir = tbl[i].ir;
      tick(1);
      if (tbl[i].wr) wr_reg(tbl[i].a, tbl[i].d);
      else           rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
    end

    // Reset asserted while the FSM sits in ACK1
    reset_dut();
    wr_reg(2'd1, 8'h00);
    ir = 8'h01; tick(2);
    bus.inta_n = 1'b0; tick(1); bus.inta_n = 1'b1; tick(1);
    ir = 8'h00;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_int", 32'(bus.intr), 32'(0));
    chk("rst_dvalid", 32'(bus.dout_valid), 32'(0));
    rst_n = 1'b1;
    tick(1);
    rd_chk("rst_imr", 2'd1, 8'hFF);
    rd_chk("rst_irr", 2'd0, 8'h00);
    bus.inta_n = 1'b0; tick(1);
    chk("rst_fsm_idle", 32'(bus.dout_valid), 32'(0));
    bus.inta_n = 1'b1; tick(1);

    // Nesting
    reset_dut();
    wr_reg(2'd3, 8'hB8); wr_reg(2'd1, 8'h00); wr_reg(2'd0, 8'h00);
    ir = 8'h08; tick(3);
    ir = 8'h0A; tick(2);
    chk("nest_int", 32'(bus.intr), 32'(1));
    ack(v, vl);
    chk("nest_vec1", 32'({vl, v}), 32'({1'b1, 8'hB9}));
    rd_chk("nest_isr1", 2'd2, 8'h02);
    rd_chk("nest_irr1", 2'd0, 8'h08);
    chk("nest_int_blocked", 32'(bus.intr), 32'(0));
    wr_reg(2'd2, 8'h00);
    chk("nest_int_eoi_a", 32'(bus.intr), 32'(0));
    tick(1);
    chk("nest_int_eoi_b", 32'(bus.intr), 32'(1));
    ack(v, vl);
    chk("nest_vec2", 32'({vl, v}), 32'({1'b1, 8'hBB}));
    rd_chk("nest_isr2", 2'd2, 8'h08);

    // Mask
    reset_dut();
    wr_reg(2'd1, 8'h08);
    ir = 8'h08; tick(2);
    chk("mask_int", 32'(bus.intr), 32'(0));
    rd_chk("mask_irr", 2'd0, 8'h08);
    wr_reg(2'd1, 8'h00);
    tick(1);
    chk("mask_int_unmask", 32'(bus.intr), 32'(1));

    // Rotate
    reset_dut();
    wr_reg(2'd3, 8'hB8); wr_reg(2'd1, 8'h00); wr_reg(2'd0, 8'h04);
    ir = 8'h05; tick(2);
    ack(v, vl);
    chk("rot_vec1", 32'({vl, v}), 32'({1'b1, 8'hB8}));
    wr_reg(2'd2, 8'h00);
    ir = 8'h04; tick(1);
    ir = 8'h05; tick(2);
    ack(v, vl);
    chk("rot_vec2", 32'({vl, v}), 32'({1'b1, 8'hBA}));
    rd_chk("rot_isr", 2'd2, 8'h04);

    // Auto-EOI
    reset_dut();
    wr_reg(2'd3, 8'hB8); wr_reg(2'd1, 8'h00); wr_reg(2'd0, 8'h02);
    ir = 8'h20; tick(2);
    ack(v, vl);
    chk("aeoi_vec", 32'({vl, v}), 32'({1'b1, 8'hBD}));
    rd_chk("aeoi_isr", 2'd2, 8'h00);

    // Spurious in level mode
    reset_dut();
    wr_reg(2'd3, 8'hB8); wr_reg(2'd1, 8'h00); wr_reg(2'd0, 8'h01);
    ir = 8'h10; tick(2);
    chk("spur_int_on", 32'(bus.intr), 32'(1));
    ir = 8'h00; tick(2);
    chk("spur_int_off", 32'(bus.intr), 32'(0));
    ack(v, vl);
    chk("spur_vec", 32'({vl, v}), 32'({1'b1, 8'hBF}));
    rd_chk("spur_isr", 2'd2, 8'h00);

    // Randomized run against the reference model (edge mode)
    reset_dut();
    m_irr = 8'h00; m_isr = 8'h00; m_ir = 8'h00; m_ptr = 0;
    m_aeoi = 1'b0; m_rot = 1'b0;
    m_base = 8'($urandom);
    wr_reg(2'd3, m_base);
    m_imr = 8'h00;
    wr_reg(2'd1, m_imr);
    for (int it = 0; it < 300; it++) begin
      if (it % 50 == 0) begin
        c = 2 * $urandom_range(0, 3);
        wr_reg(2'd0, 8'(c));
        m_aeoi = c[1];
        m_rot  = c[2];
      end
      if ($urandom_range(0, 2) == 0) begin
        nir   = 8'($urandom);
        m_irr = m_irr | (nir & ~m_ir);
        m_ir  = nir;
        ir    = nir;
      end
      tick(2);
      chk("rnd_int", 32'(bus.intr), 32'(m_winner() >= 0));
      case ($urandom_range(0, 5))
        0, 1: begin
          w = m_winner();
          if (w >= 0) begin
            e = (m_base & 8'hF8) | 8'(w);
            m_isr[w] = 1'b1;
            m_irr[w] = 1'b0;
            if (m_aeoi) begin
              m_isr[w] = 1'b0;
              if (m_rot) m_ptr = (w + 1) % 8;
            end
          end else begin
            e = m_base | 8'h07;
          end
          ack(v, vl);
          chk("rnd_vec", 32'({vl, v}), 32'({1'b1, e}));
        end
        2: begin
          sp  = 1'($urandom_range(0, 1));
          lvl = $urandom_range(0, 7);
          if (m_isr != 8'h00) begin
            w = sp ? lvl : m_top_isr();
            m_isr[w] = 1'b0;
            if (m_rot) m_ptr = (w + 1) % 8;
          end
          wr_reg(2'd2, {sp, 4'b0000, 3'(lvl)});
        end
        3: begin
          m_imr = 8'($urandom & $urandom);
          wr_reg(2'd1, m_imr);
        end
        4: rd_chk("rnd_irr", 2'd0, m_irr);
        default: rd_chk("rnd_isr", 2'd2, m_isr);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
